// File: rtl/mips_isa_pkg.sv
// Shared MIPS ISA definitions: opcode/funct table, loader request kinds and field bundle.
package mips_isa_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD   = 6'b100000;

    localparam int unsigned KIND_W  = 3;
    localparam int unsigned REG_W   = 5;
    localparam int unsigned IMM_W   = 16;
    localparam int unsigned TGT_W   = 26;
    localparam int unsigned WORD_W  = 32;

    // Request kind encoding; codes 6 and 7 are illegal.
    typedef enum logic [KIND_W-1:0] {
        KIND_ADD  = 3'd0,
        KIND_LW   = 3'd1,
        KIND_SW   = 3'd2,
        KIND_BEQ  = 3'd3,
        KIND_ADDI = 3'd4,
        KIND_J    = 3'd5
    } req_kind_e;

    typedef struct packed {
        logic [REG_W-1:0] rs;
        logic [REG_W-1:0] rt;
        logic [REG_W-1:0] rd;
        logic [IMM_W-1:0] imm;
        logic [TGT_W-1:0] target;
    } instr_fields_t;

endpackage

// File: rtl/instr_field_packer.sv
// Combinational packer: symbolic kind plus fields into a 32-bit MIPS word.
module instr_field_packer
    import mips_isa_pkg::*;
(
    input  logic [KIND_W-1:0] kind,
    input  instr_fields_t     fields,
    output logic [WORD_W-1:0] word,
    output logic              illegal
);

    // Select the instruction format for the requested kind.
    always_comb begin
        word    = '0;
        illegal = 1'b0;
        case (kind)
            KIND_ADD:  word = {OP_RTYPE, fields.rs, fields.rt, fields.rd, 5'b00000, FN_ADD};
            KIND_LW:   word = {OP_LW,    fields.rs, fields.rt, fields.imm};
            KIND_SW:   word = {OP_SW,    fields.rs, fields.rt, fields.imm};
            KIND_BEQ:  word = {OP_BEQ,   fields.rs, fields.rt, fields.imm};
            KIND_ADDI: word = {OP_ADDI,  fields.rs, fields.rt, fields.imm};
            KIND_J:    word = {OP_J,     fields.target};
            default:   illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_encoder_loader.sv
// Program loader: encodes instruction requests and writes them to consecutive
// instruction-memory word addresses through an ack-handshaked write port.
module instr_encoder_loader
    import mips_isa_pkg::*;
#(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [KIND_W-1:0]     req_kind,
    input  logic [REG_W-1:0]      req_rs,
    input  logic [REG_W-1:0]      req_rt,
    input  logic [REG_W-1:0]      req_rd,
    input  logic [IMM_W-1:0]      req_imm,
    input  logic [TGT_W-1:0]      req_target,
    input  logic                  req_last,
    input  logic                  restart,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [WORD_W-1:0]     mem_wdata,
    input  logic                  mem_ack,
    output logic                  done,
    output logic                  full,
    output logic                  err,
    output logic [ADDR_W:0]       word_count
);

    localparam int unsigned WC_W = ADDR_W + 1;
    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] LAST_ADR = {ADDR_W{1'b1}};

    localparam logic [1:0] ST_ACCEPT = 2'd0;
    localparam logic [1:0] ST_WRITE  = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    logic [1:0]        state, state_n;
    logic              last_q, last_n;
    logic              mem_we_n;
    logic [ADDR_W-1:0] mem_addr_n;
    logic [WORD_W-1:0] mem_wdata_n;
    logic              done_n, full_n, err_n;
    logic [WC_W-1:0]   word_count_n;

    logic [WORD_W-1:0] packed_word;
    logic              packed_illegal;
    instr_fields_t     fields;

    assign fields = '{rs: req_rs, rt: req_rt, rd: req_rd, imm: req_imm, target: req_target};

    instr_field_packer u_packer (
        .kind    (req_kind),
        .fields  (fields),
        .word    (packed_word),
        .illegal (packed_illegal)
    );

    assign req_ready = (state == ST_ACCEPT) && !rst;

    // Next-state and next-register computation for the loader FSM.
    always_comb begin
        state_n      = state;
        last_n       = last_q;
        mem_we_n     = mem_we;
        mem_addr_n   = mem_addr;
        mem_wdata_n  = mem_wdata;
        done_n       = done;
        full_n       = full;
        err_n        = err;
        word_count_n = word_count;
        case (state)
            ST_ACCEPT: begin
                if (req_valid) begin
                    if (packed_illegal) begin
                        // Illegal kinds are consumed without a write.
                        err_n = 1'b1;
                        if (req_last) begin
                            state_n = ST_DONE;
                            done_n  = 1'b1;
                        end
                    end else begin
                        mem_wdata_n = packed_word;
                        last_n      = req_last;
                        mem_we_n    = 1'b1;
                        state_n     = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                if (mem_we && mem_ack) begin
                    mem_we_n     = 1'b0;
                    word_count_n = word_count + WC_W'(1);
                    if (last_q) begin
                        state_n = ST_DONE;
                        done_n  = 1'b1;
                    end else if (mem_addr == LAST_ADR) begin
                        // Memory exhausted before the program ended; no wrap.
                        state_n = ST_DONE;
                        done_n  = 1'b1;
                        full_n  = 1'b1;
                    end else begin
                        mem_addr_n = mem_addr + ADDR_W'(1);
                        state_n    = ST_ACCEPT;
                    end
                end
            end
            ST_DONE: begin
                if (restart) begin
                    state_n      = ST_ACCEPT;
                    mem_addr_n   = BASE;
                    word_count_n = '0;
                    full_n       = 1'b0;
                    err_n        = 1'b0;
                    done_n       = 1'b0;
                end
            end
            default: begin
                state_n  = ST_ACCEPT;
                mem_we_n = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_ACCEPT;
            last_q     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= BASE;
            mem_wdata  <= '0;
            done       <= 1'b0;
            full       <= 1'b0;
            err        <= 1'b0;
            word_count <= '0;
        end else begin
            state      <= state_n;
            last_q     <= last_n;
            mem_we     <= mem_we_n;
            mem_addr   <= mem_addr_n;
            mem_wdata  <= mem_wdata_n;
            done       <= done_n;
            full       <= full_n;
            err        <= err_n;
            word_count <= word_count_n;
        end
    end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader: table-driven program plus corner sequences.
module tb_instr_encoder_loader;

    logic        clk;
    logic        rst, req_valid, req_ready, req_last, restart;
    logic [2:0]  req_kind;
    logic [4:0]  req_rs, req_rt, req_rd;
    logic [15:0] req_imm;
    logic [25:0] req_target;
    logic        mem_we, mem_ack, done, full, err;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [8:0]  word_count;

    logic        s_rst, s_req_valid, s_req_ready, s_restart;
    logic        s_mem_we, s_mem_ack, s_done, s_full, s_err;
    logic [1:0]  s_mem_addr;
    logic [31:0] s_mem_wdata;
    logic [2:0]  s_word_count;

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic [2:0]  kind;
        logic [4:0]  rs, rt, rd;
        logic [15:0] imm;
        logic [25:0] target;
        logic        last;
        int          delay;
        logic [31:0] exp;
    } vec_t;

    vec_t prog [5];
    vec_t v;

    instr_encoder_loader #(.ADDR_W(8), .BASE_ADDR(0)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_kind(req_kind), .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd),
        .req_imm(req_imm), .req_target(req_target), .req_last(req_last),
        .restart(restart), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .done(done), .full(full), .err(err), .word_count(word_count)
    );

    instr_encoder_loader #(.ADDR_W(2), .BASE_ADDR(0)) dut_small (
        .clk(clk), .rst(s_rst), .req_valid(s_req_valid), .req_ready(s_req_ready),
        .req_kind(req_kind), .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd),
        .req_imm(req_imm), .req_target(req_target), .req_last(req_last),
        .restart(s_restart), .mem_we(s_mem_we), .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata),
        .mem_ack(s_mem_ack), .done(s_done), .full(s_full), .err(s_err), .word_count(s_word_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Waits (bounded) for req_ready, then presents one request for one cycle.
    task automatic issue(input vec_t r);
        int n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("ready_before_req", 64'(req_ready), 64'(1));
        req_kind   = r.kind;
        req_rs     = r.rs;
        req_rt     = r.rt;
        req_rd     = r.rd;
        req_imm    = r.imm;
        req_target = r.target;
        req_last   = r.last;
        req_valid  = 1'b1;
        @(negedge clk);
        req_valid  = 1'b0;
        req_last   = 1'b0;
    endtask

    // Holds off ack for 'delay' cycles, checking the write port stays stable.
    task automatic complete_write(input int delay, input logic [31:0] exp_word, input logic [7:0] exp_addr);
        for (int d = 0; d <= delay; d++) begin
            chk("write_we", 64'(mem_we), 64'(1));
            chk("write_data", 64'(mem_wdata), 64'(exp_word));
            chk("write_addr", 64'(mem_addr), 64'(exp_addr));
            chk("ready_in_write", 64'(req_ready), 64'(0));
            if (d == delay) mem_ack = 1'b1;
            @(negedge clk);
        end
        mem_ack = 1'b0;
    endtask

    task automatic pulse_restart();
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_last = 1'b0; restart = 1'b0; mem_ack = 1'b0;
        req_kind = '0; req_rs = '0; req_rt = '0; req_rd = '0; req_imm = '0; req_target = '0;
        s_rst = 1'b1; s_req_valid = 1'b0; s_restart = 1'b0; s_mem_ack = 1'b0;

        prog[0] = '{kind: 3'd1, rs: 5'd16, rt: 5'd9,  rd: 5'd0,  imm: 16'd4,      target: 26'd0,    last: 1'b0, delay: 0, exp: 32'h8E090004};
        prog[1] = '{kind: 3'd0, rs: 5'd8,  rt: 5'd9,  rd: 5'd10, imm: 16'd0,      target: 26'd0,    last: 1'b0, delay: 3, exp: 32'h01095020};
        prog[2] = '{kind: 3'd2, rs: 5'd16, rt: 5'd10, rd: 5'd0,  imm: 16'd8,      target: 26'd0,    last: 1'b0, delay: 1, exp: 32'hAE0A0008};
        prog[3] = '{kind: 3'd3, rs: 5'd8,  rt: 5'd9,  rd: 5'd0,  imm: 16'hFFFE,   target: 26'd0,    last: 1'b0, delay: 0, exp: 32'h1109FFFE};
        prog[4] = '{kind: 3'd5, rs: 5'd0,  rt: 5'd0,  rd: 5'd0,  imm: 16'd0,      target: 26'h10,   last: 1'b1, delay: 2, exp: 32'h08000010};

        // Reset values while rst is still high.
        @(negedge clk);
        chk("rst_ready", 64'(req_ready), 64'(0));
        chk("rst_we", 64'(mem_we), 64'(0));
        chk("rst_addr", 64'(mem_addr), 64'(0));
        chk("rst_wdata", 64'(mem_wdata), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_full", 64'(full), 64'(0));
        chk("rst_err", 64'(err), 64'(0));
        chk("rst_count", 64'(word_count), 64'(0));
        rst = 1'b0;
        s_rst = 1'b0;

        // Single ADDI, ack in the same cycle mem_we rises.
        v = '{kind: 3'd4, rs: 5'd0, rt: 5'd8, rd: 5'd0, imm: 16'd5, target: 26'd0, last: 1'b1, delay: 0, exp: 32'h20080005};
        issue(v);
        complete_write(0, 32'h20080005, 8'd0);
        chk("addi_done", 64'(done), 64'(1));
        chk("addi_count", 64'(word_count), 64'(1));
        chk("addi_we_low", 64'(mem_we), 64'(0));
        chk("done_ready", 64'(req_ready), 64'(0));
        pulse_restart();
        chk("restart_done", 64'(done), 64'(0));
        chk("restart_ready", 64'(req_ready), 64'(1));
        chk("restart_addr", 64'(mem_addr), 64'(0));
        chk("restart_count", 64'(word_count), 64'(0));

        // Five-word program with delayed acks.
        for (int i = 0; i < 5; i++) begin
            issue(prog[i]);
            complete_write(prog[i].delay, prog[i].exp, 8'(i));
        end
        chk("prog_done", 64'(done), 64'(1));
        chk("prog_count", 64'(word_count), 64'(5));
        chk("prog_full", 64'(full), 64'(0));
        pulse_restart();

        // Illegal kind between two legal requests.
        issue(prog[1]);
        complete_write(0, 32'h01095020, 8'd0);
        v = prog[0];
        v.kind = 3'd7;
        issue(v);
        chk("illegal_err", 64'(err), 64'(1));
        chk("illegal_no_we", 64'(mem_we), 64'(0));
        chk("illegal_ready", 64'(req_ready), 64'(1));
        chk("illegal_count", 64'(word_count), 64'(1));
        v = prog[0];
        v.last = 1'b1;
        issue(v);
        complete_write(1, 32'h8E090004, 8'd1);
        chk("illegal_prog_done", 64'(done), 64'(1));
        chk("illegal_prog_count", 64'(word_count), 64'(2));
        chk("illegal_err_sticky", 64'(err), 64'(1));
        pulse_restart();
        chk("restart_err_clr", 64'(err), 64'(0));

        // Illegal kind marked last ends the program without a write.
        v = prog[0];
        v.kind = 3'd6;
        v.last = 1'b1;
        issue(v);
        chk("illegal_last_done", 64'(done), 64'(1));
        chk("illegal_last_err", 64'(err), 64'(1));
        chk("illegal_last_we", 64'(mem_we), 64'(0));
        chk("illegal_last_count", 64'(word_count), 64'(0));
        pulse_restart();

        // restart and a stray ack in ACCEPT are both ignored.
        issue(prog[1]);
        complete_write(0, 32'h01095020, 8'd0);
        restart = 1'b1;
        mem_ack = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        mem_ack = 1'b0;
        chk("accept_restart_addr", 64'(mem_addr), 64'(1));
        chk("accept_restart_count", 64'(word_count), 64'(1));
        chk("accept_restart_ready", 64'(req_ready), 64'(1));
        chk("stray_ack_we", 64'(mem_we), 64'(0));
        issue(prog[2]);
        complete_write(2, 32'hAE0A0008, 8'd1);

        // Reset while a write waits for ack.
        issue(prog[3]);
        chk("pre_rst_we", 64'(mem_we), 64'(1));
        chk("pre_rst_addr", 64'(mem_addr), 64'(2));
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_we", 64'(mem_we), 64'(0));
        chk("mid_rst_addr", 64'(mem_addr), 64'(0));
        chk("mid_rst_count", 64'(word_count), 64'(0));
        chk("mid_rst_ready", 64'(req_ready), 64'(0));
        rst = 1'b0;
        issue(prog[4]);
        complete_write(0, 32'h08000010, 8'd0);
        chk("post_rst_done", 64'(done), 64'(1));
        chk("post_rst_count", 64'(word_count), 64'(1));

        // ADDR_W=2 instance: six requests, only four fit.
        for (int i = 0; i < 4; i++) begin
            chk("small_ready", 64'(s_req_ready), 64'(1));
            req_kind = 3'd4; req_rs = 5'd0; req_rt = 5'(i); req_imm = 16'(i + 1); req_last = 1'b0;
            s_req_valid = 1'b1;
            @(negedge clk);
            s_req_valid = 1'b0;
            chk("small_we", 64'(s_mem_we), 64'(1));
            chk("small_addr", 64'(s_mem_addr), 64'(i));
            chk("small_data", 64'(s_mem_wdata), 64'({6'b001000, 5'd0, 5'(i), 16'(i + 1)}));
            s_mem_ack = 1'b1;
            @(negedge clk);
            s_mem_ack = 1'b0;
        end
        chk("small_full", 64'(s_full), 64'(1));
        chk("small_done", 64'(s_done), 64'(1));
        chk("small_count", 64'(s_word_count), 64'(4));
        chk("small_err", 64'(s_err), 64'(0));
        s_req_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            chk("small_full_ready", 64'(s_req_ready), 64'(0));
            @(negedge clk);
            chk("small_full_we", 64'(s_mem_we), 64'(0));
        end
        s_req_valid = 1'b0;
        s_restart = 1'b1;
        @(negedge clk);
        s_restart = 1'b0;
        chk("small_restart_full", 64'(s_full), 64'(0));
        chk("small_restart_addr", 64'(s_mem_addr), 64'(0));
        chk("small_restart_ready", 64'(s_req_ready), 64'(1));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
